// File: rtl/hash_pkg.sv
// Shared opcode encoding and packed-word width for the hash request path.
package hash_pkg;

  localparam int HASH_WORD_W = 32;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } hash_op_e;

endpackage

// File: rtl/hash_req_fifo.sv
// Circular-buffer FIFO whose head is held in a register, so dout_o is glitch-free
// and already valid in the cycle after a push into an empty queue.
module hash_req_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("hash_req_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    head_d   = head_q;
    // The word being written this cycle is the next head only when it will be the sole entry.
    if (cnt_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = din_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/hash_req_packer.sv
// Packs host READ/WRITE requests into {op, key, value} words and queues them for the
// hash-table wrapper. Optional pop statistics are enabled by HASH_REQ_PACKER_STATS_EN.
module hash_req_packer
  import hash_pkg::*;
#(
  parameter int KEY_WIDTH  = 4,
  parameter int DATA_WIDTH = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        op_i,
  input  logic [KEY_WIDTH-1:0]              key_i,
  input  logic [DATA_WIDTH-1:0]             value_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [2+KEY_WIDTH+DATA_WIDTH-1:0] data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
`ifdef HASH_REQ_PACKER_STATS_EN
  output logic [15:0]                       wr_cnt_o,
  output logic [15:0]                       rd_cnt_o,
`endif
  output logic                              err_o
);

  localparam int W = 2 + KEY_WIDTH + DATA_WIDTH;

  if (W != HASH_WORD_W) begin : g_width_check
    $error("hash_req_packer: 2+KEY_WIDTH+DATA_WIDTH must equal 32");
  end

  hash_op_e              op;
  logic                  rdy_en_q;
  logic                  err_q, err_d;
  logic                  in_hs, push, pop;
  logic                  full, empty;
  logic [DATA_WIDTH-1:0] value_pk;
  logic [W-1:0]          word;

  assign op       = hash_op_e'(op_i);
  assign in_hs    = valid_i && ready_o;
  assign push     = in_hs && (op == OP_READ || op == OP_WRITE);
  assign value_pk = (op == OP_READ) ? '0 : value_i;
  assign word     = {op_i, key_i, value_pk};
  assign err_d    = err_q || (in_hs && op == OP_ILLEGAL);

  // Holds ready_o low through reset and until the first clock edge afterwards.
  assign ready_o = rdy_en_q && !full;
  assign valid_o = !empty;
  assign pop     = valid_o && ready_i;
  assign err_o   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      err_q    <= err_d;
    end
  end

  hash_req_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_n_i (reset),
    .push_i  (push),
    .din_i   (word),
    .pop_i   (pop),
    .dout_o  (data_o),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef HASH_REQ_PACKER_STATS_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  hash_op_e    head_op;

  assign head_op = hash_op_e'(data_o[W-1 -: 2]);

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (pop && head_op == OP_WRITE && wr_cnt_q != 16'hFFFF) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (pop && head_op == OP_READ && rd_cnt_q != 16'hFFFF) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;
`endif

endmodule

// File: tb/tb_hash_req_packer.sv
// Scoreboard bench for hash_req_packer: expected words are queued at input handshake
// and checked in order as the output handshakes.
module tb_hash_req_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  op_i = 2'b00;
  logic [3:0]  key_i = '0;
  logic [25:0] value_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        err_o;
`ifdef HASH_REQ_PACKER_STATS_EN
  logic [15:0] wr_cnt_o, rd_cnt_o;
`endif

  int total = 0;
  int bad = 0;
  int n_wr = 0;
  int n_rd = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  hash_req_packer dut (
    .clk      (clk),
    .reset    (reset),
    .op_i     (op_i),
    .key_i    (key_i),
    .value_i  (value_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
`ifdef HASH_REQ_PACKER_STATS_EN
    .wr_cnt_o (wr_cnt_o),
    .rd_cnt_o (rd_cnt_o),
`endif
    .err_o    (err_o)
  );

  function automatic logic [31:0] pack(input logic [1:0] op, input logic [3:0] key,
                                       input logic [25:0] val);
    return {op, key, (op == 2'b01) ? 26'd0 : val};
  endfunction

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && valid_o && ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_unexpected data_o=%h required=none", data_o);
        end else begin
          e = exp_q.pop_front();
          if (data_o !== e) begin
            bad++;
            $display("FAIL scoreboard_order data_o=%h required=%h", data_o, e);
          end
          if (e[31:30] == 2'b10) n_wr++;
          if (e[31:30] == 2'b01) n_rd++;
        end
      end
    end
  endtask

  // Call at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [1:0] op, input logic [3:0] key, input logic [25:0] val,
                      input bit rnd_rdy);
    bit acc = 1'b0;
    op_i = op; key_i = key; value_i = val; valid_i = 1'b1;
    for (int c = 0; c < 200 && !acc; c++) begin
      if (rnd_rdy) ready_i = 1'($urandom_range(0, 1));
      #1;
      acc = ready_o;
      if (acc && (op == 2'b01 || op == 2'b10)) exp_q.push_back(pack(op, key, val));
      @(negedge clk);
    end
    valid_i = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_timeout op=%0d key=%0d accepted=0 required=1", op, key);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      #3;
      done = (exp_q.size() == 0) && !valid_o;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain pending=%0d valid_o=%b required pending=0 valid_o=0",
               exp_q.size(), valid_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #5;
    total++;
    if ({valid_o, ready_o, err_o} !== 3'b000 || data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs valid/ready/err=%b%b%b data_o=%h required 000 and 0",
               valid_o, ready_o, err_o, data_o);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge ready_o=%b required=0", ready_o);
    end
    @(negedge clk);
    #1;
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_edge ready_o=%b required=1", ready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_write_latency();
    ready_i = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL write_pre_valid valid_o=%b required=0", valid_o);
    end
    send(2'b10, 4'd6, 26'd2, 1'b0);
    #1;
    total++;
    if (valid_o !== 1'b1 || data_o !== 32'h9800_0002) begin
      bad++;
      $display("FAIL write_latency valid_o=%b data_o=%h required 1 98000002", valid_o, data_o);
    end
    @(negedge clk);
    #1;
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL write_single_cycle valid_o=%b required=0", valid_o);
    end
    @(negedge clk);
  endtask

  task automatic test_read_zero();
    ready_i = 1'b1;
    send(2'b01, 4'hD, 26'h3FF_FFFF, 1'b0);
    #1;
    total++;
    if (valid_o !== 1'b1 || data_o !== 32'h7400_0000) begin
      bad++;
      $display("FAIL read_zero valid_o=%b data_o=%h required 1 74000000", valid_o, data_o);
    end
    @(negedge clk);
    drain();
  endtask

  task automatic test_backpressure();
    logic [25:0] v0;
    v0 = 26'($urandom);
    ready_i = 1'b0;
    send(2'b10, 4'd0, v0, 1'b0);
    for (int k = 1; k < 4; k++) send(2'b10, 4'(k), 26'($urandom), 1'b0);
    #1;
    total++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_full ready_o=%b valid_o=%b required 0 1", ready_o, valid_o);
    end
    op_i = 2'b10; key_i = 4'd4; value_i = 26'h123_4567; valid_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      total++;
      if (ready_o !== 1'b0 || data_o !== pack(2'b10, 4'd0, v0)) begin
        bad++;
        $display("FAIL bp_hold ready_o=%b data_o=%h required 0 %h", ready_o, data_o,
                 pack(2'b10, 4'd0, v0));
      end
    end
    @(negedge clk);
    ready_i = 1'b1;
    send(2'b10, 4'd4, 26'h123_4567, 1'b0);
    drain();
  endtask

  task automatic test_full_push_pop();
    ready_i = 1'b0;
    for (int k = 8; k < 12; k++) send(2'(1 + (k & 1)), 4'(k), 26'($urandom), 1'b0);
    ready_i = 1'b1;
    op_i = 2'b10; key_i = 4'hF; value_i = 26'h0AB_CDEF; valid_i = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_pushpop_reject ready_o=%b required=0", ready_o);
    end
    @(negedge clk);
    #1;
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL full_pushpop_rise ready_o=%b required=1", ready_o);
    end
    exp_q.push_back(pack(2'b10, 4'hF, 26'h0AB_CDEF));
    @(negedge clk);
    valid_i = 1'b0;
    drain();
  endtask

  task automatic test_illegal();
    ready_i = 1'b1;
    #1;
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_before err_o=%b required=0", err_o);
    end
    @(negedge clk);
    send(2'b11, 4'd3, 26'h155_5555, 1'b0);
    #1;
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_set err_o=%b required=1", err_o);
    end
    @(negedge clk);
    send(2'b00, 4'd7, 26'h2AA_AAAA, 1'b0);
    repeat (3) begin
      #1;
      total++;
      if (valid_o !== 1'b0 || err_o !== 1'b1) begin
        bad++;
        $display("FAIL err_hold valid_o=%b err_o=%b required 0 1", valid_o, err_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 2)), 4'($urandom), 26'($urandom), 1'b1);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
`ifdef HASH_REQ_PACKER_STATS_EN
    total++;
    if (wr_cnt_o !== 16'(n_wr) || rd_cnt_o !== 16'(n_rd)) begin
      bad++;
      $display("FAIL stats_count wr=%0d rd=%0d required %0d %0d", wr_cnt_o, rd_cnt_o, n_wr, n_rd);
    end
`endif
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) send(2'b10, 4'(k + 5), 26'($urandom), 1'b0);
    #3 reset = 1'b0;
    #1;
    total++;
    if ({valid_o, ready_o, err_o} !== 3'b000 || data_o !== 32'h0) begin
      bad++;
      $display("FAIL midflight_reset valid/ready/err=%b%b%b data_o=%h required 000 and 0",
               valid_o, ready_o, err_o, data_o);
    end
    exp_q.delete();
    n_wr = 0;
    n_rd = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({valid_o, ready_o, err_o} !== 3'b010) begin
      bad++;
      $display("FAIL post_reset valid/ready/err=%b%b%b required 010", valid_o, ready_o, err_o);
    end
`ifdef HASH_REQ_PACKER_STATS_EN
    total++;
    if (wr_cnt_o !== 16'd0 || rd_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL stats_reset wr=%0d rd=%0d required 0 0", wr_cnt_o, rd_cnt_o);
    end
`endif
    @(negedge clk);
    ready_i = 1'b1;
    send(2'b10, 4'd9, 26'h000_0042, 1'b0);
    drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_write_latency();
    test_read_zero();
    test_backpressure();
    test_full_push_pop();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout elapsed=500000 required=completion");
    $fatal(1, "watchdog");
  end

endmodule
